// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared geometry, character codes and VGA timing for the text frame path
package frame_pkg;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  localparam logic [5:0] CH_SPACE = 6'd10;
  localparam logic [5:0] CH_A     = 6'd11;
  localparam logic [5:0] CH_ARROW = 6'd37;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {ST_IDLE, ST_CLEAR} clear_state_t;

  // row*40 + col as shift-adds: (row<<5) + (row<<3) + col
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] col, input logic [5:0] row);
    logic [ADDR_W-1:0] r;
    r = {5'b0, row};
    return (r << 5) + (r << 3) + {5'b0, col};
  endfunction

endpackage

// File: rtl/font_rom.sv
// rtl/font_rom.sv - 64-glyph x 8-row font ROM, one registered read per enabled cycle
module font_rom
  import frame_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic [5:0] code,
  input  logic [2:0] row,
  output logic [7:0] bits
);

  logic [63:0] glyph;

  // Top row in the most significant byte, leftmost pixel in bit 7 of each row
  always_comb begin
    glyph = 64'h0;
    case (code)
      6'd0:     glyph = 64'h3C666E7666663C00;
      6'd1:     glyph = 64'h1838181818187E00;
      6'd2:     glyph = 64'h3C66060C30607E00;
      6'd3:     glyph = 64'h3C66061C06663C00;
      6'd4:     glyph = 64'h0C1C3C6C7E0C0C00;
      6'd5:     glyph = 64'h7E607C0606663C00;
      6'd6:     glyph = 64'h3C607C6666663C00;
      6'd7:     glyph = 64'h7E660C1818181800;
      6'd8:     glyph = 64'h3C66663C66663C00;
      6'd9:     glyph = 64'h3C66663E06663C00;
      CH_SPACE: glyph = 64'h0;
      6'd11:    glyph = 64'h183C667E66666600;
      6'd12:    glyph = 64'h7C66667C66667C00;
      6'd13:    glyph = 64'h3C66606060663C00;
      6'd14:    glyph = 64'h786C6666666C7800;
      6'd15:    glyph = 64'h7E60607860607E00;
      6'd16:    glyph = 64'h7E60607860606000;
      6'd17:    glyph = 64'h3C66606E66663C00;
      6'd18:    glyph = 64'h6666667E66666600;
      6'd19:    glyph = 64'h3C18181818183C00;
      6'd20:    glyph = 64'h1E0C0C0C0C6C3800;
      6'd21:    glyph = 64'h666C7870786C6600;
      6'd22:    glyph = 64'h6060606060607E00;
      6'd23:    glyph = 64'h63777F6B63636300;
      6'd24:    glyph = 64'h66767E7E6E666600;
      6'd25:    glyph = 64'h3C66666666663C00;
      6'd26:    glyph = 64'h7C66667C60606000;
      6'd27:    glyph = 64'h3C666666663C0E00;
      6'd28:    glyph = 64'h7C66667C786C6600;
      6'd29:    glyph = 64'h3C66603C06663C00;
      6'd30:    glyph = 64'h7E18181818181800;
      6'd31:    glyph = 64'h6666666666663C00;
      6'd32:    glyph = 64'h66666666663C1800;
      6'd33:    glyph = 64'h6363636B7F776300;
      6'd34:    glyph = 64'h66663C183C666600;
      6'd35:    glyph = 64'h6666663C18181800;
      6'd36:    glyph = 64'h7E060C1830607E00;
      CH_ARROW: glyph = 64'h00180C7E0C180000;
      default:  glyph = 64'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (en) begin
      bits <= glyph[{3'd7 - row, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/text_frame_renderer.sv
// rtl/text_frame_renderer.sv - 40x30 character buffer scanned out as 640x480@60 VGA with 2x glyphs
module text_frame_renderer
  import frame_pkg::*;
#(
  parameter logic [23:0] FG_RGB = 24'h00FF00,
  parameter logic [23:0] BG_RGB = 24'h000000
) (
  input  logic       clk,
  input  logic       frame_reset_n,
  input  logic [5:0] frame_char,
  input  logic [5:0] frame_x,
  input  logic [5:0] frame_y,
  input  logic       frame_we,
  input  logic       frame_clear,
  output logic       clear_busy,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_clk
);

  clear_state_t      state;
  logic [ADDR_W-1:0] clear_addr;
  logic              in_range;
  logic              host_wr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [5:0]        wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [5:0]        frame_ram [CELLS];

  logic              pix_en;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic              hs_now, vs_now, blank_now;
  logic              hs1, vs1, blank1;
  logic              hs2, vs2, blank2;
  logic [2:0]        col1, row1, col2;
  logic [5:0]        char1;
  logic [7:0]        glyph_bits;
  logic              pixel_on;

  always_ff @(posedge clk or negedge frame_reset_n) begin
    if (!frame_reset_n) begin
      state      <= ST_CLEAR;
      clear_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_clear) begin
            state      <= ST_CLEAR;
            clear_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (frame_clear) begin
            clear_addr <= '0;
          end else if (clear_addr == LAST_ADDR) begin
            state <= ST_IDLE;
          end else begin
            clear_addr <= clear_addr + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign clear_busy = (state == ST_CLEAR);

  // A clear request in the same cycle as a host write takes priority
  assign in_range = (frame_x < 6'(COLS)) && (frame_y < 6'(ROWS));
  assign host_wr  = frame_we && (state == ST_IDLE) && !frame_clear && in_range;
  assign wr_en    = clear_busy || host_wr;
  assign wr_addr  = clear_busy ? clear_addr : cell_addr(frame_x, frame_y);
  assign wr_data  = clear_busy ? CH_SPACE : frame_char;
  assign rd_addr  = cell_addr(hcount[9:4], vcount[9:4]);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_ram[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_en) begin
      char1 <= frame_ram[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge frame_reset_n) begin
    if (!frame_reset_n) begin
      pix_en  <= 1'b0;
      vga_clk <= 1'b0;
      hcount  <= '0;
      vcount  <= '0;
    end else begin
      pix_en  <= ~pix_en;
      vga_clk <= pix_en;
      if (pix_en) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  assign hs_now    = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
  assign vs_now    = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
  assign blank_now = (hcount < H_ACT_END) && (vcount < V_ACT_END);

  // Syncs and blank ride alongside the RAM and font ROM stages
  always_ff @(posedge clk or negedge frame_reset_n) begin
    if (!frame_reset_n) begin
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      blank1 <= 1'b0;
      col1   <= '0;
      row1   <= '0;
      hs2    <= 1'b1;
      vs2    <= 1'b1;
      blank2 <= 1'b0;
      col2   <= '0;
    end else if (pix_en) begin
      hs1    <= hs_now;
      vs1    <= vs_now;
      blank1 <= blank_now;
      col1   <= hcount[3:1];
      row1   <= vcount[3:1];
      hs2    <= hs1;
      vs2    <= vs1;
      blank2 <= blank1;
      col2   <= col1;
    end
  end

  font_rom u_font_rom (
    .clk  (clk),
    .en   (pix_en),
    .code (char1),
    .row  (row1),
    .bits (glyph_bits)
  );

  assign pixel_on    = glyph_bits[3'd7 - col2];
  assign vga_hs      = hs2;
  assign vga_vs      = vs2;
  assign vga_blank_n = blank2;
  assign vga_r       = blank2 ? (pixel_on ? FG_RGB[23:16] : BG_RGB[23:16]) : 8'h00;
  assign vga_g       = blank2 ? (pixel_on ? FG_RGB[15:8]  : BG_RGB[15:8])  : 8'h00;
  assign vga_b       = blank2 ? (pixel_on ? FG_RGB[7:0]   : BG_RGB[7:0])   : 8'h00;

endmodule

// File: tb/tb_text_frame_renderer.sv
// tb/tb_text_frame_renderer.sv - directed bench for text_frame_renderer scan-out, writes and clears
module tb_text_frame_renderer;

  localparam int N_LINES = 20;

  logic       clk;
  logic       frame_reset_n;
  logic [5:0] frame_char;
  logic [5:0] frame_x;
  logic [5:0] frame_y;
  logic       frame_we;
  logic       frame_clear;
  logic       clear_busy;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_clk;

  int   tests;
  int   fails;
  bit   mon_done;
  logic [5:0] shadow [1200];

  text_frame_renderer dut (
    .clk           (clk),
    .frame_reset_n (frame_reset_n),
    .frame_char    (frame_char),
    .frame_x       (frame_x),
    .frame_y       (frame_y),
    .frame_we      (frame_we),
    .frame_clear   (frame_clear),
    .clear_busy    (clear_busy),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs),
    .vga_blank_n   (vga_blank_n),
    .vga_clk       (vga_clk)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] font_bits(input logic [5:0] code);
    case (code)
      6'd7:    return 64'h7E660C1818181800;
      6'd11:   return 64'h183C667E66666600;
      6'd37:   return 64'h00180C7E0C180000;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [26:0] pix_model(input int h, input int v);
    logic        hs, vs, bl, on;
    logic [63:0] g;
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    bl = (h < 640) && (v < 480);
    on = 1'b0;
    if (bl) begin
      g  = font_bits(shadow[(v / 16) * 40 + h / 16]);
      on = g[63 - 8 * ((v / 2) % 8) - ((h / 2) % 8)];
    end
    return {hs, vs, bl, (bl && on) ? 24'h00FF00 : 24'h000000};
  endfunction

  task automatic wr(input int x, input int y, input int c);
    frame_x    = 6'(x);
    frame_y    = 6'(y);
    frame_char = 6'(c);
    frame_we   = 1'b1;
    @(posedge clk);
    #1;
    frame_we = 1'b0;
    if (x < 40 && y < 30) shadow[y * 40 + x] = 6'(c);
  endtask

  // Raster monitor: sample k after reset release carries pixel k-1
  initial begin : monitor
    int s, p, h, v, hs_low, fg;
    logic [26:0] ow, ew;
    logic [31:0] so, se;
    s = 0; hs_low = 0; fg = 0; so = 0; se = 0;
    forever begin
      @(negedge clk);
      if (!frame_reset_n) begin
        s = 0;
      end else if (vga_clk && !mon_done) begin
        if (s >= 1) begin
          p = s - 1;
          h = p % 800;
          v = p / 800;
          if (h == 0) begin
            so = 0; se = 0; hs_low = 0; fg = 0;
          end
          ow = {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b};
          ew = pix_model(h, v);
          so = (so * 33) ^ {5'b0, ow};
          se = (se * 33) ^ {5'b0, ew};
          if (!vga_hs) hs_low++;
          if (vga_g == 8'hFF) fg++;
          if (h == 799 && v >= 1) begin
            check($sformatf("line%0d_sig", v), so, se);
            check($sformatf("line%0d_hs_low", v), hs_low, 96);
            if (v == 1 || v == 2) check($sformatf("line%0d_fg", v), fg, 16);
            if (v == N_LINES) mon_done = 1'b1;
          end
        end
        s++;
      end
    end
  end

  initial begin
    int n;
    tests = 0; fails = 0;
    for (int i = 0; i < 1200; i++) shadow[i] = 6'd10;
    frame_reset_n = 1'b0;
    frame_char = '0; frame_x = '0; frame_y = '0;
    frame_we = 1'b0; frame_clear = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", clear_busy, 1);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_blank_n", vga_blank_n, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_vga_clk", vga_clk, 0);

    // Initial sweep; a host write mid-sweep must be dropped
    @(negedge clk);
    frame_reset_n = 1'b1;
    n = 0;
    while (clear_busy && n < 5000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 600) begin
        frame_x = 6'd5; frame_y = 6'd0; frame_char = 6'd7; frame_we = 1'b1;
      end else begin
        frame_we = 1'b0;
      end
    end
    check("init_clear_len", n, 1200);

    wr(0, 0, 7);
    wr(39, 0, 11);
    wr(40, 0, 1);
    wr(45, 0, 37);
    wr(1, 1, 37);

    n = 0;
    while (!mon_done && n < 60000) begin
      @(posedge clk);
      n++;
    end
    check("monitor_done", mon_done, 1);

    // Clear and write together, then a restart partway through the sweep
    #1;
    check("idle_before_clear", clear_busy, 0);
    frame_clear = 1'b1;
    frame_we = 1'b1; frame_x = 6'd2; frame_y = 6'd3; frame_char = 6'd37;
    @(posedge clk);
    #1;
    frame_clear = 1'b0;
    frame_we = 1'b0;
    check("clear_rise", clear_busy, 1);
    n = 0;
    while (clear_busy && n < 5000) begin
      @(posedge clk);
      n++;
      #1;
      frame_clear = (n == 300);
    end
    frame_clear = 1'b0;
    check("restart_clear_len", n, 1501);

    // Asynchronous reset at clear_addr = 600
    frame_clear = 1'b1;
    @(posedge clk);
    #1;
    frame_clear = 1'b0;
    for (int i = 0; i < 600; i++) @(posedge clk);
    #1;
    if (!vga_clk) begin
      @(posedge clk);
      #1;
    end
    #3;
    frame_reset_n = 1'b0;
    #1;
    check("async_busy", clear_busy, 1);
    check("async_hs", vga_hs, 1);
    check("async_vs", vga_vs, 1);
    check("async_blank_n", vga_blank_n, 0);
    check("async_rgb", {vga_r, vga_g, vga_b}, 0);
    check("async_vga_clk", vga_clk, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    frame_reset_n = 1'b1;
    n = 0;
    while (clear_busy && n < 5000) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("reclear_len", n, 1200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/text_frame_renderer.md
Name: text_frame_renderer

Overview:
- Consumes the character-write stream produced by the cycle printer (frame_char/frame_x/frame_y/frame_we) and stores it in a 40x30 character frame buffer.
- Scans the buffer continuously and drives a 640x480@60 VGA output. Each character occupies a 16x16 pixel cell: an 8x8 glyph scaled 2x.
- Sits between the cycle-print stage and the board VGA DAC.

Parameters:
- COLS, 40, characters per row
- ROWS, 30, character rows
- FG_RGB, 24'h00FF00, glyph pixel colour {R,G,B}
- BG_RGB, 24'h000000, background colour

Ports:
- clk  in  1  system clock, 50 MHz
- frame_reset_n  in  1  asynchronous, active-low reset
- frame_char  in  6  character code to write
- frame_x  in  6  column, 0..COLS-1
- frame_y  in  6  row, 0..ROWS-1
- frame_we  in  1  write strobe, one write per cycle
- frame_clear  in  1  pulse: re-blank the whole buffer
- clear_busy  out  1  high while a blanking sweep runs
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- vga_hs, vga_vs  out  1  syncs, active low
- vga_blank_n  out  1  high in the active region
- vga_clk  out  1  pixel clock, 25 MHz (clk/2)

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - pix_en = 0, hcount = 0, vcount = 0
  - vga_hs = 1, vga_vs = 1, vga_blank_n = 0
  - vga_r/g/b = 0, vga_clk = 0
  - clear_busy = 1; the clear FSM enters CLEAR with clear_addr = 0.
- Pixel enable: pix_en toggles every clk; vga_clk = pix_en registered. All scan logic advances only when pix_en = 1.
- Horizontal timing, 800 per line: active 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical timing, 525 per frame: active 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Counter wrap: hcount wraps 799 to 0 and increments vcount; vcount wraps 524 to 0.
- Buffer: 1200 x 6-bit dual-port RAM.
  - Write address = frame_y*COLS + frame_x.
  - Read address = (vcount>>4)*COLS + (hcount>>4), computed with shift-adds (y*40 = (y<<5)+(y<<3)); no multipliers.
- Character codes:
  - 0-9: digits
  - 10: space
  - 11-36: A-Z
  - 37: arrow "->"
  - 38-63: rendered as blank.
- Read pipeline, latency 2 pixel clocks:
  - stage 1: RAM read;
  - stage 2: font ROM lookup at {char, (vcount>>1)&7}, then bit select (hcount>>1)&7 with MSB = leftmost pixel.
- hs, vs and blank are delayed 2 pixel clocks to align with the pixel data.
- vga_r/g/b = FG_RGB when the glyph bit is 1, BG_RGB otherwise; 0 whenever delayed blank is low.
- Clear FSM, states IDLE and CLEAR:
  - CLEAR writes code 10 to clear_addr every clk, then increments; at clear_addr = 1199 it goes to IDLE.
  - IDLE goes to CLEAR (clear_addr = 0) on frame_clear.
  - clear_busy = (state == CLEAR).
- Write rules:
  - Host writes (frame_we) are dropped while clear_busy = 1.
  - Writes with frame_x >= COLS or frame_y >= ROWS are dropped; no wrap.
  - frame_clear asserted while already in CLEAR restarts at address 0.
  - frame_clear and frame_we in the same cycle: the clear wins and the write is dropped.
- Write-to-display: a write becomes visible on the next scan of that cell. Read-during-write to the same address may return old data (RAM old-data mode).
- While clear_busy = 1, the scan keeps running; pixels show buffer contents, which are partially cleared.
- Reset asserted mid-frame or mid-clear: everything returns to the reset state immediately, and clearing restarts after release.

Decomposition:
- Shared package frame_pkg holds:
  - COLS/ROWS
  - char code constants: CH_SPACE = 10, CH_ARROW = 37, CH_A = 11
  - VGA timing constants: H_ACTIVE, H_FP, H_SYNC, H_BP, V_* equivalents.
- The cycle printer imports the same char constants.
- Sub-module font_rom: 64x8 rows of 8 bits, synchronous read, 1-cycle latency, initialised from a .mif/.hex file.

Test Plan:
- Reset release -> clear_busy high for exactly 1200 clks, then low. A readback of cell (39,29) renders as all-background pixels.
- Write frame_char = 7 at (0,0) after the clear -> in frame N+1, pixels x 0-15 / y 0-15 match glyph '7' scaled 2x, with pixel (0,0) appearing 2 pixel clocks after hcount = 0.
- Write frame_x = 40, frame_y = 5, char 1 -> the buffer is unchanged and no pixel in row 5 changes.
- Count pix_en over one frame -> vga_hs low for 96 pixels per line at hcount 656-751 (delayed 2), vga_vs low for lines 490-491, and 800x525 pixel clocks per frame.
- Write char 37 at (2,3) and pulse frame_clear in the same cycle -> the write is dropped, clear_busy rises next cycle, and the cell renders blank after the sweep.
- Assert frame_reset_n low at clear_addr = 600 -> outputs take reset values asynchronously; after release, the sweep restarts at 0 and takes 1200 clks.
